// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - multiplexed 7-segment scanner for packed BCD
// One digit is lit per DRIVE phase, with a DEAD gap between digits; the input is snapshotted per frame.
module bcd_display_scan #(
  parameter int DIGITS = 5,
  parameter int DWELL  = 1000,
  parameter int DEAD   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  enable,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int MAXC = (DWELL > DEAD) ? DWELL : DEAD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_DRIVE} state_t;

  state_t               state, state_n;
  logic [IW-1:0]        idx, idx_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [4*DIGITS-1:0]  snap, snap_n;
  logic [6:0]           seg_n;
  logic [DIGITS-1:0]    an_n;
  logic                 fd_n;
  logic [DIGITS-1:0]    blank;
  logic                 lz_run;
  logic [3:0]           cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // A digit blanks only while every more-significant digit is a true zero; invalid codes break the run.
  always_comb begin
    blank  = '0;
    lz_run = blank_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run   = lz_run && (snap[4*i +: 4] == 4'd0);
      blank[i] = lz_run;
    end
  end

  assign cur_digit = snap[4*idx +: 4];

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    snap_n  = snap;
    seg_n   = SEG_OFF;
    an_n    = '1;
    fd_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_n = S_DEAD;
          idx_n   = '0;
          cnt_n   = '0;
          snap_n  = value;
        end
      end
      S_DEAD: begin
        if (cnt == DEAD_LAST) begin
          state_n = S_DRIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRIVE: begin
        an_n[idx] = 1'b0;
        seg_n     = blank[idx] ? SEG_OFF : decode(cur_digit);
        if (cnt == DWELL_LAST) begin
          state_n = S_DEAD;
          cnt_n   = '0;
          if (idx == IDX_LAST) begin
            idx_n  = '0;
            snap_n = value;
            fd_n   = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Disable overrides everything, including a frame-end snapshot; frame_done is left alone.
    if (!enable) begin
      state_n = S_IDLE;
      idx_n   = '0;
      cnt_n   = '0;
      snap_n  = snap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      snap       <= '0;
      seg        <= SEG_OFF;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      snap       <= snap_n;
      seg        <= seg_n;
      an         <= an_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Multiplexed 7-segment scanner that sits directly downstream of the 5-digit BCD counter. It consumes the counter's 20-bit packed BCD value and time-multiplexes it onto a common-anode display: one digit lit at a time, with dead time between digits to suppress ghosting. It also provides optional leading-zero blanking and a tear-free per-frame snapshot of the input.

## Interface
- `DIGITS`, 5, number of BCD digits scanned (digit 0 = `value[3:0]`, least significant).
- `DWELL`, 1000, clk cycles each digit is driven (≥1).
- `DEAD`, 16, clk cycles all digits are off between digits (≥1).
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `value` in 4*DIGITS: packed BCD from counter, digit i = `value[4i+3:4i]`.
- `enable` in 1: 0 = display dark and FSM idle.
- `blank_lz` in 1: 1 = leading-zero blanking on.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `an` out DIGITS: digit anodes, active-low, at most one low.
- `frame_done` out 1: one-cycle pulse at end of each full scan frame.

## Operation
- FSM states: IDLE, DEAD, DRIVE. Registers: `state`, `idx` (0..DIGITS-1), `cnt` (sized for max(DWELL,DEAD)-1), `snap` (4*DIGITS).
- Reset: state=IDLE, idx=0, cnt=0, snap=0, seg=7'b1111111, an=all ones, frame_done=0.
- IDLE: if enable=1 → DEAD, idx=0, cnt=0, snap←value (frame start).
- DEAD: cnt counts 0..DEAD-1; at DEAD-1 → DRIVE, cnt=0.
- DRIVE: cnt counts 0..DWELL-1; at DWELL-1:
  - if idx<DIGITS-1 → DEAD, idx+1;
  - if idx=DIGITS-1 → DEAD, idx=0, snap←value, frame_done=1 for one cycle.
- enable=0 in any state → IDLE on the next edge (idx/cnt cleared, snap held). Re-enable always restarts at digit 0 with a fresh snapshot.
- snap loads only at frame start. Changes on `value` mid-frame are not visible until the next frame.
- Leading-zero blanking, computed from snap: digit i (i≥1) is blank if blank_lz=1 and snap digits DIGITS-1 down to i are all 0. Digit 0 is never blanked (value 0 shows "0").
- Decode, active-low `{g..a}`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 (invalid BCD) = dash 0111111
  - blank = 1111111
- Invalid digits do not count as zero for blanking.
- `an` and `seg` are registered.
  - In DRIVE, `an[idx]`=0 and `seg`=decode(snap digit idx), or 1111111 if blanked; the anode is still asserted.
  - In IDLE or DEAD, `an`=all ones and `seg`=1111111.

## Timing
- `an`/`seg` lag the FSM state by one cycle (output register). `frame_done` is registered with the same one-cycle lag, asserted the cycle after the final DRIVE cycle of digit DIGITS-1.
- Frame period = DIGITS*(DEAD+DWELL) cycles; default 5080.
- From enable=1 sampled in IDLE: first `an` low appears DEAD+2 cycles later (1 edge to DEAD, DEAD cycles, 1 output-register cycle).
- Every DEAD→DRIVE and DRIVE→DEAD boundary: `an` is never low for two different digits on the same or adjacent cycles. At least DEAD all-off cycles separate consecutive lit digits.
- Reset asserted mid-frame: outputs go dark asynchronously (seg=1111111, an=all ones) with no clock needed. After deassert, operation resumes from IDLE.
- Simultaneous frame end and enable=0: enable wins → IDLE, and no snapshot is taken. frame_done still pulses.

## Test plan
- Reset then enable=1, DEAD=2, DWELL=4, value=20'h12345 → an cycles 11110,11101,11011,10111,01111, each low 4 cycles with 2-cycle gaps. seg shows 5,4,3,2,1. frame_done pulses every 30 cycles.
- value=20'h00042, blank_lz=1 → digits 4,3,2 blank (seg=1111111 while their anode is low). Digits 1,0 show 4,2. With blank_lz=0 the display shows 0,0,0,4,2.
- value=0, blank_lz=1 → only digit 0 shows 1000000. value=20'h0A000 → digit 3 shows dash and digit 4 is blanked.
- Change value from 20'h11111 to 20'h99999 mid-frame → the rest of the frame still shows 1. The next frame shows 9 on all digits.
- Drop enable during DRIVE of digit 2 → one cycle later all outputs are off. Re-enable → restarts at digit 0 with a new snapshot.
- Assert reset asynchronously between clock edges during DRIVE → an=11111 and seg=1111111 immediately, frame_done=0. On release, operation resumes as in the first scenario.
